// File: rtl/vec3_length.sv
// -----------------------------------------------------------------------------
// vec3_length
//
// Iterative CORDIC magnitude unit. Returns |(x,y,z)| of a signed 16-bit
// 3-vector using one shift-add micro-rotation per clock. Two vectoring passes
// run back to back. The first folds (x,y) into a single leg. The second folds
// that leg with z.
//
// Parameters
//   ITERS      micro-rotations per pass, legal range 4..15 (default 8)
//
// Ports
//   clk        in   1   clock
//   reset      in   1   synchronous, active-high reset
//   start      in   1   request, accepted only while busy = 0
//   xin/yin/zin in  16  signed operands, sampled on the accepting edge
//   busy       out  1   high while a computation is in flight
//   done       out  1   one-cycle pulse when len becomes valid
//   len        out  20  unsigned magnitude, held until the next done
//
// Build option
//   VEC3LEN_GAIN_COMP_EN  when defined, an extra COMP cycle scales the raw
//                         K^2-gained result back to a true magnitude.
//                         When undefined, len is the raw K^2-scaled value.
// -----------------------------------------------------------------------------
module vec3_length #(
  parameter int unsigned ITERS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] xin,
  input  logic signed [15:0] yin,
  input  logic signed [15:0] zin,
  output logic               busy,
  output logic               done,
  output logic        [19:0] len
);

  localparam logic [3:0] I_LAST = 4'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS1,
`ifdef VEC3LEN_GAIN_COMP_EN
    S_PASS2,
    S_COMP
`else
    S_PASS2
`endif
  } state_e;

  state_e             state_q, state_d;
  logic        [3:0]  i_q, i_d;
  logic signed [19:0] a_q, a_d;
  logic signed [19:0] b_q, b_d;
  logic        [15:0] c_q, c_d;
  logic        [19:0] len_q, len_d;
  logic               done_q, done_d;

  // Absolute value with -32768 saturating to 32767 so it fits 15 bits.
  function automatic logic [15:0] abs_sat(input logic signed [15:0] v);
    logic [15:0] r;
    if (v == 16'sh8000) begin
      r = 16'h7fff;
    end else if (v < 0) begin
      r = 16'(-v);
    end else begin
      r = 16'(v);
    end
    return r;
  endfunction

  // The first pass leaves its leg multiplied by the CORDIC gain K. The z leg
  // enters the second pass multiplied by the same K (1.64648, shift-add form)
  // so both legs share one scale and the result is K^2*|xyz|.
  function automatic logic signed [19:0] gain_scale(input logic [15:0] v);
    logic [19:0] w;
    w = {4'b0000, v};
    return signed'(w + (w >> 1) + (w >> 3) + (w >> 6) + (w >> 8) + (w >> 9));
  endfunction

`ifdef VEC3LEN_GAIN_COMP_EN
  // 1/K^2 ~= 1/4 + 1/8 - 1/128 + 1/1024 = 0.36816
  function automatic logic [19:0] gain_comp(input logic [19:0] r);
    return (r >> 2) + (r >> 3) - (r >> 7) + (r >> 10);
  endfunction
`endif

  // One vectoring micro-rotation. Both updates use the old a/b. The sign of
  // b picks the rotation direction that drives b toward zero.
  logic signed [19:0] a_sh, b_sh, a_rot, b_rot;

  always_comb begin
    a_sh = a_q >>> i_q;
    b_sh = b_q >>> i_q;
    if (!b_q[19]) begin
      a_rot = a_q + b_sh;
      b_rot = b_q - a_sh;
    end else begin
      a_rot = a_q - b_sh;
      b_rot = b_q + a_sh;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    len_d   = len_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = {4'b0000, abs_sat(xin)};
          b_d     = {4'b0000, abs_sat(yin)};
          c_d     = abs_sat(zin);
          i_d     = '0;
          state_d = S_PASS1;
        end
      end

      S_PASS1: begin
        a_d = a_rot;
        b_d = b_rot;
        i_d = i_q + 4'd1;
        if (i_q == I_LAST) begin
          // Rotated a is K*|xy|. The z leg becomes the new b.
          b_d     = gain_scale(c_q);
          i_d     = '0;
          state_d = S_PASS2;
        end
      end

      S_PASS2: begin
        a_d = a_rot;
        b_d = b_rot;
        i_d = i_q + 4'd1;
        if (i_q == I_LAST) begin
          i_d = '0;
`ifdef VEC3LEN_GAIN_COMP_EN
          state_d = S_COMP;
`else
          // a_rot is non-negative and below 2^18, so it maps straight to len.
          len_d   = a_rot;
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end

`ifdef VEC3LEN_GAIN_COMP_EN
      S_COMP: begin
        len_d   = gain_comp(a_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the datapath registers carry no reset. They are always loaded on
  // the accepting edge before they are read, so a reset would only add
  // fan-out on the reset net.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    c_q <= c_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign len  = len_q;

endmodule
